cflog_loop_expander: RTL and testbench

Verifier-side decoder for the loop-compressed control-flow log (CFLog) written by the CFA hardware monitor. It consumes a stream of log entries, each either a plain (src, dest) transfer or a loop-count word. It re-expands every count word into the repeated transfers it stands for and emits a flat (src, dest) stream over a valid/ready handshake. It sits between the CFLog reader (memory or DMA side) and the path-verification engine.

---
 rtl/cflog_loop_expander.sv | 125 ++++++++++++
 tb/tb_cflog_loop_expander.sv | 567 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cflog_loop_expander.sv
// cflog_loop_expander: re-expands a loop-compressed CFLog stream.
// Plain (src, dest) entries pass straight through; a count word C that
// follows a plain entry stands for C-2 further copies of that entry, which
// are replayed one per cycle while the input is held off.
//
// Handshake (both sides): a beat transfers on a posedge where valid && ready.
// A producer holds valid and its payload stable until that edge; out_valid is
// never withdrawn and out_src/out_dest/out_rep do not change while
// out_valid && !out_ready. in_ready never depends on in_valid.
module cflog_loop_expander #(
    parameter int ADDR_W = 16,
    parameter int CTR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_loop,
    input  logic [ADDR_W-1:0] in_src,
    input  logic [ADDR_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_src,
    output logic [ADDR_W-1:0] out_dest,
    output logic              out_rep,
    output logic              busy,
    input  logic              abort,
    output logic              err_orphan,
    output logic              err_count,
    output logic              dbg_state
);

    typedef enum logic {
        PASS   = 1'b0,
        REPEAT = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] hist_src;
    logic [ADDR_W-1:0] hist_dest;
    logic              hist_valid;
    logic [CTR_W-1:0]  rem;

    logic              slot_free;
    logic              accept;
    logic [CTR_W-1:0]  count_word;

    // A count word is carried across both address fields, high half in src.
    assign count_word = {in_src, in_dest};
    assign slot_free  = !out_valid || out_ready;
    // Input is only taken in PASS, with room in the output register, and
    // never while an abort or reset is being applied.
    assign in_ready   = rst_n && (state == PASS) && slot_free && !abort;
    assign accept     = in_valid && in_ready;
    assign busy       = (state == REPEAT);
    assign dbg_state  = state;

    // Output register, history, remaining-copy counter, FSM and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PASS;
            rem        <= '0;
            hist_src   <= '0;
            hist_dest  <= '0;
            hist_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_src    <= '0;
            out_dest   <= '0;
            out_rep    <= 1'b0;
            err_orphan <= 1'b0;
            err_count  <= 1'b0;
        end else if (abort) begin
            // Abort flushes the expansion but lets a registered beat drain.
            state      <= PASS;
            rem        <= '0;
            hist_valid <= 1'b0;
            err_orphan <= 1'b0;
            err_count  <= 1'b0;
            if (out_ready) begin
                out_valid <= 1'b0;
            end
        end else if (state == PASS) begin
            if (accept && !in_loop) begin
                out_valid  <= 1'b1;
                out_src    <= in_src;
                out_dest   <= in_dest;
                out_rep    <= 1'b0;
                hist_src   <= in_src;
                hist_dest  <= in_dest;
                hist_valid <= 1'b1;
            end else begin
                // No new beat this edge: the slot empties if it was consumed.
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
                if (accept) begin
                    if (!hist_valid) begin
                        err_orphan <= 1'b1;
                    end else if (count_word < CTR_W'(3)) begin
                        err_count  <= 1'b1;
                        hist_valid <= 1'b0;
                    end else begin
                        // The counter started at 2, so C means C-2 extra copies.
                        rem        <= count_word - CTR_W'(2);
                        hist_valid <= 1'b0;
                        state      <= REPEAT;
                    end
                end
            end
        end else begin
            // REPEAT: replay the history pair whenever the slot can take it.
            if (slot_free) begin
                out_valid <= 1'b1;
                out_src   <= hist_src;
                out_dest  <= hist_dest;
                out_rep   <= 1'b1;
                rem       <= rem - CTR_W'(1);
                if (rem == CTR_W'(1)) begin
                    state <= PASS;
                end
            end
        end
    end

endmodule

// File: tb/tb_cflog_loop_expander.sv
// Testbench for cflog_loop_expander: scenario tasks drive entries, a
// reference model expands them into the expected beat list, and a negedge
// monitor records every consumed output beat for comparison.
module tb_cflog_loop_expander;

    localparam int AW = 16;
    localparam int BW = 2 * AW + 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_loop;
    logic [AW-1:0] in_src;
    logic [AW-1:0] in_dest;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_src;
    logic [AW-1:0] out_dest;
    logic          out_rep;
    logic          busy;
    logic          abort;
    logic          err_orphan;
    logic          err_count;
    logic          dbg_state;

    int vectors;
    int miscompares;
    int cyc;
    int ready_mode;
    int ready_phase;
    int stall_viol;
    int busy_cyc;
    int ready_viol;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] obs_q[$];
    int            obs_cyc_q[$];

    bit            m_hist_valid;
    logic [AW-1:0] m_hist_src;
    logic [AW-1:0] m_hist_dest;
    bit            m_err_orphan;
    bit            m_err_count;

    bit            prev_stall;
    logic [BW-1:0] prev_beat;

    cflog_loop_expander #(.ADDR_W(AW), .CTR_W(2 * AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_loop    (in_loop),
        .in_src     (in_src),
        .in_dest    (in_dest),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_src    (out_src),
        .out_dest   (out_dest),
        .out_rep    (out_rep),
        .busy       (busy),
        .abort      (abort),
        .err_orphan (err_orphan),
        .err_count  (err_count),
        .dbg_state  (dbg_state)
    );

    // Clock, cycle counter and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // out_ready driver: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
    initial begin
        ready_phase = 0;
        forever begin
            @(posedge clk);
            #1;
            ready_phase++;
            if (ready_mode == 0) out_ready = 1'b1;
            else if (ready_mode == 1) out_ready = ((ready_phase % 3) == 0);
            else out_ready = 1'(($urandom_range(0, 1)));
        end
    end

    // Monitor: record consumed beats, stall stability, busy window.
    initial begin
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (!out_valid || ({out_rep, out_src, out_dest} !== prev_beat)))
                    stall_viol++;
                if (out_valid && out_ready) begin
                    obs_q.push_back({out_rep, out_src, out_dest});
                    obs_cyc_q.push_back(cyc);
                end
                prev_stall = out_valid && !out_ready;
                prev_beat  = {out_rep, out_src, out_dest};
                if (busy) busy_cyc++;
                if (busy && in_ready) ready_viol++;
            end
        end
    end

    // Reference model: expand one accepted entry into expected beats.
    function automatic void model_entry(input bit loop, input logic [AW-1:0] s,
                                        input logic [AW-1:0] d);
        longint unsigned c;
        if (!loop) begin
            exp_q.push_back({1'b0, s, d});
            m_hist_valid = 1'b1;
            m_hist_src   = s;
            m_hist_dest  = d;
        end else begin
            c = longint'({s, d});
            if (!m_hist_valid) begin
                m_err_orphan = 1'b1;
            end else begin
                m_hist_valid = 1'b0;
                if (c < 3) m_err_count = 1'b1;
                else for (longint unsigned i = 0; i < c - 2; i++)
                    exp_q.push_back({1'b1, m_hist_src, m_hist_dest});
            end
        end
    endfunction

    function automatic void model_abort();
        m_hist_valid = 1'b0;
        m_err_orphan = 1'b0;
        m_err_count  = 1'b0;
    endfunction

    // Index of the first differing beat, or -1 when both lists match.
    function automatic int first_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // Drive one entry until accepted; all tasks start 1 time unit after a posedge.
    task automatic send_entry(input bit loop, input logic [AW-1:0] s, input logic [AW-1:0] d,
                              input bit use_model, output int acc_cyc);
        bit done;
        int n;
        in_valid = 1'b1;
        in_loop  = loop;
        in_src   = s;
        in_dest  = d;
        done     = 1'b0;
        n        = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        acc_cyc  = -1;
        if (done) begin
            acc_cyc = cyc;
            if (use_model) model_entry(loop, s, d);
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout entry loop=%0b src=%h dest=%h not accepted", loop, s, d);
        end
    endtask

    task automatic wait_drain(input int bound);
        bit done;
        int n;
        done = 1'b0;
        n    = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            if (!busy && !out_valid) done = 1'b1;
            n++;
        end
        @(posedge clk);
        #1;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout busy=%0b out_valid=%0b after %0d cycles", busy, out_valid, bound);
        end
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        model_abort();
    endtask

    task automatic clear_sb();
        obs_q.delete();
        obs_cyc_q.delete();
        exp_q.delete();
        stall_viol = 0;
        busy_cyc   = 0;
        ready_viol = 0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({in_ready, out_valid, out_rep, busy, err_orphan, err_count, out_src, out_dest} !== '0) begin
            miscompares++;
            $display("FAIL reset_values got rdy=%0b ov=%0b rep=%0b busy=%0b eo=%0b ec=%0b src=%h dst=%h exp all 0",
                     in_ready, out_valid, out_rep, busy, err_orphan, err_count, out_src, out_dest);
        end
        rst_n = 1'b1;
        model_abort();
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_in_ready got=%0b exp=1", in_ready);
        end
        clear_sb();
    endtask

    task automatic test_pass_through();
        int a1, a2, d;
        ready_mode = 0;
        send_entry(1'b0, 16'hE000, 16'hE010, 1'b1, a1);
        vectors++;
        if ({out_valid, out_rep, out_src, out_dest} !== {2'b10, 16'hE000, 16'hE010}) begin
            miscompares++;
            $display("FAIL pt_latency got ov=%0b rep=%0b %h/%h exp 1 0 e000/e010", out_valid, out_rep, out_src, out_dest);
        end
        send_entry(1'b0, 16'hE020, 16'hE004, 1'b1, a2);
        vectors++;
        if (a2 !== a1 + 1) begin
            miscompares++;
            $display("FAIL pt_back_to_back accept cycle got=%0d exp=%0d", a2, a1 + 1);
        end
        wait_drain(50);
        d = first_diff();
        vectors++;
        if (d >= 0) begin
            miscompares++;
            $display("FAIL pt_stream beat %0d got=%h exp=%h n_got=%0d n_exp=%0d", d, obs_q[d], exp_q[d], obs_q.size(), exp_q.size());
        end
        vectors++;
        if (obs_cyc_q.size() != 2 || obs_cyc_q[1] != obs_cyc_q[0] + 1) begin
            miscompares++;
            $display("FAIL pt_output_spacing got n=%0d exp 2 beats on consecutive cycles", obs_cyc_q.size());
        end
        clear_sb();
    endtask

    task automatic test_loop_expansion();
        int a0, k, a3, d;
        ready_mode = 0;
        send_entry(1'b0, 16'hE10A, 16'hE100, 1'b1, a0);
        send_entry(1'b1, 16'h0000, 16'h0005, 1'b1, k);
        vectors++;
        if ({busy, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL loop_accept_edge got busy=%0b ov=%0b exp busy=1 ov=0", busy, out_valid);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, out_rep, out_src, out_dest} !== {2'b11, 16'hE10A, 16'hE100}) begin
            miscompares++;
            $display("FAIL loop_first_copy got ov=%0b rep=%0b %h/%h exp 1 1 e10a/e100", out_valid, out_rep, out_src, out_dest);
        end
        send_entry(1'b0, 16'hE200, 16'hE201, 1'b1, a3);
        vectors++;
        if (a3 !== k + 4) begin
            miscompares++;
            $display("FAIL loop_next_accept cycle got=%0d exp=%0d", a3, k + 4);
        end
        wait_drain(50);
        d = first_diff();
        vectors++;
        if (d >= 0) begin
            miscompares++;
            $display("FAIL loop_stream beat %0d got=%h exp=%h n_got=%0d n_exp=%0d", d, obs_q[d], exp_q[d], obs_q.size(), exp_q.size());
        end
        vectors++;
        if (busy_cyc !== 3 || ready_viol !== 0) begin
            miscompares++;
            $display("FAIL loop_busy_window got busy_cycles=%0d ready_in_busy=%0d exp 3 and 0", busy_cyc, ready_viol);
        end
        clear_sb();
    endtask

    task automatic test_backpressure();
        int a, d;
        ready_mode = 1;
        send_entry(1'b0, 16'hE10A, 16'hE100, 1'b1, a);
        send_entry(1'b1, 16'h0000, 16'h0005, 1'b1, a);
        wait_drain(100);
        d = first_diff();
        vectors++;
        if (d >= 0) begin
            miscompares++;
            $display("FAIL bp_stream beat %0d got=%h exp=%h n_got=%0d n_exp=%0d", d, obs_q[d], exp_q[d], obs_q.size(), exp_q.size());
        end
        vectors++;
        if (stall_viol !== 0) begin
            miscompares++;
            $display("FAIL bp_stall_stable got=%0d unstable stalls exp=0", stall_viol);
        end
        ready_mode = 0;
        clear_sb();
    endtask

    task automatic test_errors();
        int a, d;
        ready_mode = 0;
        do_abort();
        send_entry(1'b1, 16'h0000, 16'h0005, 1'b1, a);
        vectors++;
        if ({err_orphan, err_count, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL err_orphan_first got eo=%0b ec=%0b busy=%0b exp 1 0 0", err_orphan, err_count, busy);
        end
        wait_drain(20);
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL err_orphan_no_output got %0d beats exp 0", obs_q.size());
        end
        do_abort();
        clear_sb();
        send_entry(1'b0, 16'h0001, 16'h0002, 1'b1, a);
        send_entry(1'b1, 16'h0000, 16'h0002, 1'b1, a);
        vectors++;
        if ({err_orphan, err_count, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL err_count_c2 got eo=%0b ec=%0b busy=%0b exp 0 1 0", err_orphan, err_count, busy);
        end
        wait_drain(20);
        d = first_diff();
        vectors++;
        if (d >= 0) begin
            miscompares++;
            $display("FAIL err_count_stream beat %0d got=%h exp=%h n_got=%0d n_exp=%0d", d, obs_q[d], exp_q[d], obs_q.size(), exp_q.size());
        end
        do_abort();
        clear_sb();
        send_entry(1'b0, 16'h0003, 16'h0004, 1'b1, a);
        send_entry(1'b1, 16'h0000, 16'h0004, 1'b1, a);
        send_entry(1'b1, 16'h0000, 16'h0004, 1'b1, a);
        vectors++;
        if ({err_orphan, err_count} !== 2'b10) begin
            miscompares++;
            $display("FAIL err_double_count got eo=%0b ec=%0b exp 1 0", err_orphan, err_count);
        end
        wait_drain(20);
        d = first_diff();
        vectors++;
        if (d >= 0) begin
            miscompares++;
            $display("FAIL err_double_stream beat %0d got=%h exp=%h n_got=%0d n_exp=%0d", d, obs_q[d], exp_q[d], obs_q.size(), exp_q.size());
        end
        do_abort();
        clear_sb();
    endtask

    task automatic test_large_count();
        int a, d;
        ready_mode = 0;
        send_entry(1'b0, 16'h1234, 16'h5678, 1'b1, a);
        send_entry(1'b1, 16'h0001, 16'h0002, 1'b1, a);
        wait_drain(70000);
        d = first_diff();
        vectors++;
        if (d >= 0 || exp_q.size() != 32'h10001) begin
            miscompares++;
            $display("FAIL large_stream beat %0d got=%h exp=%h n_got=%0d n_exp=%0d", d, obs_q[d], exp_q[d], obs_q.size(), exp_q.size());
        end
        vectors++;
        if (busy !== 1'b0 || busy_cyc !== 32'h10000) begin
            miscompares++;
            $display("FAIL large_busy got busy=%0b busy_cycles=%0d exp 0 and 65536", busy, busy_cyc);
        end
        clear_sb();
        send_entry(1'b0, 16'h1111, 16'h2222, 1'b1, a);
        send_entry(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, a);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if ({busy, out_valid, out_rep} !== 3'b111) begin
            miscompares++;
            $display("FAIL max_count_running got busy=%0b ov=%0b rep=%0b exp 1 1 1", busy, out_valid, out_rep);
        end
        do_abort();
        wait_drain(20);
        clear_sb();
    endtask

    task automatic test_abort();
        int a, d;
        ready_mode = 0;
        send_entry(1'b1, 16'h0000, 16'h0003, 1'b1, a);
        send_entry(1'b0, 16'hA000, 16'hB000, 1'b1, a);
        send_entry(1'b1, 16'h0000, 16'h000A, 1'b1, a);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        model_abort();
        // Copies loaded on the two edges before abort are all that may appear.
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        vectors++;
        if ({busy, err_orphan, err_count, out_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL abort_state got busy=%0b eo=%0b ec=%0b ov=%0b exp all 0", busy, err_orphan, err_count, out_valid);
        end
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        d = first_diff();
        vectors++;
        if (d >= 0) begin
            miscompares++;
            $display("FAIL abort_stream beat %0d got=%h exp=%h n_got=%0d n_exp=%0d", d, obs_q[d], exp_q[d], obs_q.size(), exp_q.size());
        end
        clear_sb();
    endtask

    task automatic test_reset_mid_repeat();
        int a, d;
        ready_mode = 0;
        send_entry(1'b0, 16'hC000, 16'hC001, 1'b1, a);
        send_entry(1'b1, 16'h0000, 16'h000A, 1'b1, a);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, busy, in_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_mid_repeat got ov=%0b busy=%0b rdy=%0b exp 0 0 0", out_valid, busy, in_ready);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_abort();
        // Pass beat and the first copy were consumed before reset.
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        d = first_diff();
        vectors++;
        if (d >= 0) begin
            miscompares++;
            $display("FAIL rst_stream beat %0d got=%h exp=%h n_got=%0d n_exp=%0d", d, obs_q[d], exp_q[d], obs_q.size(), exp_q.size());
        end
        clear_sb();
    endtask

    task automatic test_random();
        int a, d;
        bit lp;
        logic [AW-1:0] s, t;
        ready_mode = 2;
        do_abort();
        clear_sb();
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            lp = ($urandom_range(0, 9) < 3);
            if (lp) begin
                s = '0;
                t = AW'($urandom_range(0, 6));
            end else begin
                s = AW'($urandom);
                t = AW'($urandom);
            end
            send_entry(lp, s, t, 1'b1, a);
        end
        wait_drain(200);
        d = first_diff();
        vectors++;
        if (d >= 0) begin
            miscompares++;
            $display("FAIL rand_stream beat %0d got=%h exp=%h n_got=%0d n_exp=%0d", d, obs_q[d], exp_q[d], obs_q.size(), exp_q.size());
        end
        vectors++;
        if ({err_orphan, err_count} !== {m_err_orphan, m_err_count}) begin
            miscompares++;
            $display("FAIL rand_flags got eo=%0b ec=%0b exp eo=%0b ec=%0b", err_orphan, err_count, m_err_orphan, m_err_count);
        end
        vectors++;
        if (stall_viol !== 0 || ready_viol !== 0) begin
            miscompares++;
            $display("FAIL rand_protocol got unstable=%0d ready_in_busy=%0d exp 0 0", stall_viol, ready_viol);
        end
        ready_mode = 0;
        clear_sb();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ready_mode  = 0;
        rst_n       = 1'b1;
        abort       = 1'b0;
        in_valid    = 1'b0;
        in_loop     = 1'b0;
        in_src      = '0;
        in_dest     = '0;
        out_ready   = 1'b1;
        model_abort();
        clear_sb();
        test_reset();
        test_pass_through();
        test_loop_expansion();
        test_backpressure();
        test_errors();
        test_large_count();
        test_abort();
        test_reset_mid_repeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
